// File: rtl/updn_ctrl_pkg.sv
// Shared types and defaults for the up/down counter control stage.
package updn_ctrl_pkg;

  typedef enum logic {
    DIR_DN = 1'b0,
    DIR_UP = 1'b1
  } dir_state_t;

  localparam int unsigned DEB_CYCLES_DEF = 4;
  localparam int unsigned Q_W_DEF        = 4;

endpackage

// File: rtl/updn_ctrl_if.sv
// Button, counter-value and direction signals between the control stage and its surroundings.
interface updn_ctrl_if
  import updn_ctrl_pkg::*;
#(
  parameter int unsigned Q_W = Q_W_DEF
);
  logic           btn_up;
  logic           btn_dn;
  logic [Q_W-1:0] q;
  logic           updn;
  logic           dir_evt;

  modport master (
    output btn_up,
    output btn_dn,
    output q,
    input  updn,
    input  dir_evt
  );

  modport slave (
    input  btn_up,
    input  btn_dn,
    input  q,
    output updn,
    output dir_evt
  );
endinterface

// File: rtl/btn_debounce.sv
// One push-button: 2-flop synchroniser, debounce counter, stable level and press pulse.
module btn_debounce #(
  parameter int unsigned DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic press,
  output logic stable
);

  localparam int unsigned    CntW    = $clog2(DEB_CYCLES) + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DEB_CYCLES - 1);

  logic            r_sync1, r_sync2;
  logic            r_stable, r_stable_dly;
  logic [CntW-1:0] r_cnt;
  logic [CntW-1:0] w_cnt_nxt;
  logic            w_stable_nxt;

  // Count consecutive differing cycles; any agreeing cycle restarts the count.
  always_comb begin
    w_cnt_nxt    = '0;
    w_stable_nxt = r_stable;
    if (r_sync2 != r_stable) begin
      if (r_cnt == CntLast) begin
        w_stable_nxt = r_sync2;
      end else begin
        w_cnt_nxt = r_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1      <= 1'b0;
      r_sync2      <= 1'b0;
      r_stable     <= 1'b0;
      r_stable_dly <= 1'b0;
      r_cnt        <= '0;
    end else begin
      r_sync1      <= btn_raw;
      r_sync2      <= r_sync1;
      r_stable     <= w_stable_nxt;
      r_stable_dly <= r_stable;
      r_cnt        <= w_cnt_nxt;
    end
  end

  assign press  = r_stable & ~r_stable_dly;
  assign stable = r_stable;

endmodule

// File: rtl/updn_ctrl.sv
// Direction control for the up/down counter: debounced UP/DOWN buttons drive a 2-state FSM.
// Define UPDN_CTRL_AUTO_REVERSE_EN to reverse automatically at the counter's end values.
module updn_ctrl
  import updn_ctrl_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int unsigned Q_W        = Q_W_DEF,
  parameter logic        UPDN_RST   = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  updn_ctrl_if.slave  bus
);

  logic       w_up_press, w_dn_press;
  logic       w_up_stable, w_dn_stable;
  logic       w_q_max, w_q_zero;
  dir_state_t r_state, w_state_nxt;
  logic       r_dir_evt;

  btn_debounce #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_deb_up (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (bus.btn_up),
    .press   (w_up_press),
    .stable  (w_up_stable)
  );

  btn_debounce #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_deb_dn (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (bus.btn_dn),
    .press   (w_dn_press),
    .stable  (w_dn_stable)
  );

  assign w_q_max  = (bus.q == {Q_W{1'b1}});
  assign w_q_zero = (bus.q == '0);

`ifdef UPDN_CTRL_AUTO_REVERSE_EN
  logic w_any_press;
  assign w_any_press = w_up_press | w_dn_press;
`else
  logic w_unused_q;
  assign w_unused_q = w_q_max | w_q_zero;
`endif

  logic w_unused_stable;
  assign w_unused_stable = w_up_stable | w_dn_stable;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      DIR_DN: begin
        if (w_up_press && !w_dn_press) begin
          w_state_nxt = DIR_UP;
        end
`ifdef UPDN_CTRL_AUTO_REVERSE_EN
        else if (!w_any_press && w_q_zero) begin
          w_state_nxt = DIR_UP;
        end
`endif
      end
      DIR_UP: begin
        if (w_dn_press && !w_up_press) begin
          w_state_nxt = DIR_DN;
        end
`ifdef UPDN_CTRL_AUTO_REVERSE_EN
        else if (!w_any_press && w_q_max) begin
          w_state_nxt = DIR_DN;
        end
`endif
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= dir_state_t'(UPDN_RST);
      r_dir_evt <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_dir_evt <= (w_state_nxt != r_state);
    end
  end

  assign bus.updn    = r_state;
  assign bus.dir_evt = r_dir_evt;

endmodule
